// File: rtl/mux_arbiter_rr_if.sv
// Channel-side and output-side bus of the N-way mux/arbiter.
// The master modport belongs to the producer/consumer environment; the slave modport belongs to the block.
interface mux_arbiter_rr_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [SW-1:0]  Controlador;
  logic [N*W-1:0] Entradas;
  logic [N-1:0]   Valido;
  logic [N-1:0]   Pronto;
  logic [W-1:0]   Saida;
  logic           SaidaValida;
  logic           Aceito;
  logic [SW-1:0]  Canal;

  modport master (
    output Controlador, Entradas, Valido, Aceito,
    input  Pronto, Saida, SaidaValida, Canal
  );

  modport slave (
    input  Controlador, Entradas, Valido, Aceito,
    output Pronto, Saida, SaidaValida, Canal
  );
endinterface

// File: rtl/mux_arbiter_rr.sv
// N-channel valid/ready multiplexer with a one-word output register.
// The source is chosen by Controlador (MODE=0) or by a rotating round-robin search (MODE=1).
module mux_arbiter_rr #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0
) (
  input  logic            Clock,
  input  logic            Reset,
  mux_arbiter_rr_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  saida_q;
  logic [SW-1:0] canal_q;
  logic          saida_valida;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_next;
  logic [SW-1:0] sel;
  logic [N-1:0]  grant;
  logic          any_valid;
  logic          load_ok;
  logic          in_xfer;
  int            scan;

  // Grants are forced off while Reset is low so Pronto stays quiet during reset.
  always_comb begin
    grant     = '0;
    sel       = '0;
    any_valid = 1'b0;
    scan      = 0;
    load_ok   = Reset && (!saida_valida || bus.Aceito);
    if (MODE == 0) begin
      sel = bus.Controlador;
      if (load_ok && (int'(bus.Controlador) < N))
        grant[bus.Controlador] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        scan = int'(ptr) + k;
        if (scan >= N)
          scan = scan - N;
        if (!any_valid && bus.Valido[scan]) begin
          any_valid = 1'b1;
          sel       = SW'(scan);
        end
      end
      if (load_ok && any_valid)
        grant[sel] = 1'b1;
    end
  end

  always_comb begin
    in_xfer = |(grant & bus.Valido);
    if (int'(sel) == N - 1)
      ptr_next = '0;
    else
      ptr_next = sel + SW'(1);
  end

  // A new word may overwrite the held one in the same edge it is consumed.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      saida_q      <= '0;
      canal_q      <= '0;
      saida_valida <= 1'b0;
      ptr          <= '0;
    end else begin
      if (in_xfer) begin
        saida_q      <= bus.Entradas[int'(sel)*W +: W];
        canal_q      <= sel;
        saida_valida <= 1'b1;
      end else if (saida_valida && bus.Aceito) begin
        saida_valida <= 1'b0;
      end
      if ((MODE != 0) && in_xfer)
        ptr <= ptr_next;
    end
  end

  always_comb begin
    bus.Pronto      = grant;
    bus.Saida       = saida_q;
    bus.Canal       = canal_q;
    bus.SaidaValida = saida_valida;
  end
endmodule

// File: doc/mux_arbiter_rr.md
MUX_ARBITER_RR -- requirements
Module: mux_arbiter_rr

Interface
REQ-001 The block SHALL have parameter N, default 4: number of input channels, 2..16.
REQ-002 The block SHALL have parameter W, default 8: data width per channel, 1..32.
REQ-003 The block SHALL have parameter MODE, default 0: 0 = fixed select via Controlador, 1 = round-robin arbitration.
REQ-004 The block SHALL have port Clock, input, 1 bit: single clock, all state on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port Controlador, input, clog2(N) bits: channel select, used only when MODE=0.
REQ-007 The block SHALL have port Entradas, input, N*W bits: channel i data occupies bits [i*W +: W].
REQ-008 The block SHALL have port Valido, input, N bits: per-channel request/valid.
REQ-009 The block SHALL have port Pronto, output, N bits: per-channel ready (grant).
REQ-010 The block SHALL have port Saida, output, W bits: registered output data.
REQ-011 The block SHALL have port SaidaValida, output, 1 bit: Saida holds an unconsumed word.
REQ-012 The block SHALL have port Aceito, input, 1 bit: downstream ready.
REQ-013 The block SHALL have port Canal, output, clog2(N) bits: source channel of the word in Saida.

Function
REQ-014 The block SHALL transfer on channel i in a cycle where Valido[i]=1 and Pronto[i]=1.
REQ-015 The block SHALL transfer on the output in a cycle where SaidaValida=1 and Aceito=1.
REQ-016 The block SHALL set load_ok = !SaidaValida | Aceito; while load_ok=0, Pronto SHALL be all zeros.
REQ-017 Pronto SHALL be one-hot or zero, and combinational from Valido, Controlador, the pointer, SaidaValida and Aceito.
REQ-018 In MODE=0, Pronto[Controlador] SHALL be 1 iff load_ok=1; an out-of-range Controlador (>= N) SHALL grant nothing.
REQ-019 In MODE=1, grant SHALL go to the first i with Valido[i]=1, searching from the pointer upward and wrapping N-1 -> 0.
REQ-020 In MODE=1, only one such channel SHALL receive Pronto, and only when load_ok=1.
REQ-021 In MODE=1, the pointer SHALL become (granted+1) mod N on each input transfer and SHALL be unchanged otherwise.
REQ-022 On an input transfer from channel i, the next edge SHALL load Saida = Entradas[i*W +: W], set Canal = i and set SaidaValida = 1, giving a latency of 1 cycle.
REQ-023 On an output transfer with no simultaneous input transfer, SaidaValida SHALL clear; Saida and Canal SHALL hold their values.
REQ-024 Simultaneous output and input transfers SHALL replace the word with no bubble, giving one word per cycle sustained.
REQ-025 While SaidaValida=1 and Aceito=0, Saida and Canal SHALL be stable and no channel SHALL be granted.
REQ-026 With no Valido asserted, the block SHALL grant nothing and leave the pointer unchanged.
REQ-027 In MODE=0, a Controlador change mid-stream SHALL take effect the same cycle and SHALL NOT affect a word already registered.

Reset
REQ-028 While Reset=0, SaidaValida SHALL be 0, Saida 0, Canal 0, pointer 0, and Pronto all zeros, asynchronously.
REQ-029 Reset asserted mid-operation SHALL discard any held word; the first grant after release SHALL be searched from channel 0.
REQ-030 Reset release SHALL be sampled synchronously, and the first load SHALL be allowed on the first edge after release.

Verification
REQ-031 MODE=0, N=4, W=8, Controlador=2, Valido=4'b0100, Entradas ch2=8'hA5, Aceito=1 -> Pronto=4'b0100; next edge Saida=8'hA5, Canal=2, SaidaValida=1.
REQ-032 MODE=1, Valido=4'b1111 held, Aceito=1 -> grants in order ch0, ch1, ch2, ch3, ch0 on consecutive cycles; one output word per cycle.
REQ-033 MODE=1, pointer=3, Valido=4'b0011 -> ch0 granted (wrap), pointer becomes 1; next cycle ch1 granted.
REQ-034 Hold Aceito=0 with a word held at 8'h3C -> Pronto=0, Saida stays 8'h3C for 5 cycles; on Aceito=1, ch data 8'h11 is loaded the same edge, with no bubble.
REQ-035 Assert Reset=0 mid-stream with SaidaValida=1 -> SaidaValida=0, Saida=0 immediately, without a clock edge; after release, MODE=1 with Valido=4'b1000 grants ch3 and the pointer then becomes 0.
REQ-036 MODE=0, N=3, Controlador=3 with all Valido=1 -> Pronto=0 and SaidaValida stays 0.
